// File: rtl/cache_refill_ctrl.sv
// Miss-handling engine: samples the PLRU victim way, writes back a dirty victim,
// burst-reads the missing line, fills it into the chosen way and marks that way MRU.
module cache_refill_ctrl #(
    parameter int SET_ASSOC   = 4,
    parameter int LINE_WORDS  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 7,
    localparam int OFF_W = $clog2(LINE_WORDS * DATA_WIDTH / 8),
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - OFF_W,
    localparam int WAY_W = $clog2(SET_ASSOC),
    localparam int LINE_W = LINE_WORDS * DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_req,
    input  logic [ADDR_WIDTH-1:0]  miss_addr,
    output logic                   miss_ready,
    input  logic [WAY_W-1:0]       repl_index,
    output logic [SET_ASSOC-1:0]   repl_access,
    output logic                   repl_update,
    output logic                   tag_rd_en,
    output logic [INDEX_WIDTH-1:0] tag_rd_index,
    output logic [WAY_W-1:0]       tag_rd_way,
    input  logic                   vic_valid,
    input  logic                   vic_dirty,
    input  logic [TAG_W-1:0]       vic_tag,
    input  logic [LINE_W-1:0]      vic_data,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_gnt,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic                   mem_wready,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_rvalid,
    output logic                   line_we,
    output logic [INDEX_WIDTH-1:0] line_index,
    output logic [WAY_W-1:0]       line_way,
    output logic [TAG_W-1:0]       line_tag,
    output logic [LINE_W-1:0]      line_wdata,
    output logic                   refill_done
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
    localparam logic [SET_ASSOC-1:0] WAY_ONE = {{(SET_ASSOC-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE, LOOKUP, CHECK, WB_REQ, WB_DATA, RD_REQ, RD_DATA, FILL
    } state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [WAY_W-1:0]       way_q;
    logic [LINE_W-1:0]      line_q;
    logic [BEAT_W-1:0]      beat;
    logic [INDEX_WIDTH-1:0] index_q;

    assign index_q = addr_q[OFF_W +: INDEX_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            miss_ready  <= 1'b1;
            tag_rd_en   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            line_we     <= 1'b0;
            refill_done <= 1'b0;
            repl_update <= 1'b0;
            repl_access <= '0;
            addr_q      <= '0;
            way_q       <= '0;
            line_q      <= '0;
            beat        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_req && miss_ready) begin
                        addr_q     <= miss_addr & ~OFF_MASK;
                        miss_ready <= 1'b0;
                        tag_rd_en  <= 1'b1;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    way_q     <= repl_index;
                    tag_rd_en <= 1'b0;
                    state     <= CHECK;
                end
                CHECK: begin
                    // The victim tag is captured straight into the writeback address.
                    line_q  <= vic_data;
                    mem_req <= 1'b1;
                    if (vic_valid && vic_dirty) begin
                        mem_we   <= 1'b1;
                        mem_addr <= {vic_tag, index_q, {OFF_W{1'b0}}};
                        state    <= WB_REQ;
                    end else begin
                        mem_we   <= 1'b0;
                        mem_addr <= addr_q;
                        state    <= RD_REQ;
                    end
                end
                WB_REQ: begin
                    if (mem_gnt) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                        beat     <= '0;
                        state    <= WB_DATA;
                    end
                end
                WB_DATA: begin
                    if (mem_wready) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            mem_req  <= 1'b1;
                            mem_addr <= addr_q;
                            state    <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_gnt) begin
                        mem_req  <= 1'b0;
                        mem_addr <= '0;
                        beat     <= '0;
                        state    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    // The victim copy is fully drained by now, so the buffer is reused for the refill.
                    if (mem_rvalid) begin
                        line_q[beat*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            line_we     <= 1'b1;
                            refill_done <= 1'b1;
                            repl_update <= 1'b1;
                            repl_access <= WAY_ONE << way_q;
                            state       <= FILL;
                        end
                    end
                end
                FILL: begin
                    line_we     <= 1'b0;
                    refill_done <= 1'b0;
                    repl_update <= 1'b0;
                    repl_access <= '0;
                    miss_ready  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_wdata    = (state == WB_DATA) ? line_q[beat*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign tag_rd_index = tag_rd_en ? index_q : '0;
    assign tag_rd_way   = tag_rd_en ? repl_index : '0;
    assign line_index   = line_we ? index_q : '0;
    assign line_way     = line_we ? way_q : '0;
    assign line_tag     = line_we ? addr_q[ADDR_WIDTH-1 -: TAG_W] : '0;
    assign line_wdata   = line_we ? line_q : '0;

endmodule
